// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants, common
// host command bytes and the odd-parity helper used when building a frame.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;

  localparam logic [PS2_DATA_BITS-1:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [PS2_DATA_BITS-1:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [PS2_DATA_BITS-1:0] PS2_CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StWaitFirst,
    StShift,
    StAck,
    StWaitIdle,
    StAbort
  } ps2_tx_state_t;

  // Odd parity: the data bits plus the parity bit always hold an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status interface of the PS/2 host transmitter.
//   tx_data/tx_valid/tx_ready : command byte handshake (accept on valid && ready)
//   busy                      : transmit in progress; receivers should ignore the lines
//   tx_done/tx_ack_err/tx_timeout : one-cycle completion pulses, exactly one per byte
// master = command issuer, slave = transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     busy;
  logic                     tx_done;
  logic                     tx_ack_err;
  logic                     tx_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 line.
//   clk, reset : system clock, asynchronous active-high reset
//   line       : raw line level
//   level      : synchronized level
//   fall       : one-cycle pulse when the synchronized level goes 1 -> 0
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta_q;
  logic level_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      meta_q  <= line;
      level_q <= meta_q;
      prev_q  <= level_q;
    end
  end

  assign level = level_q;
  assign fall  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Runs the request-to-send sequence (clock
// inhibit, data low, clock release), then shifts start/data/odd parity/stop on
// device falling edges and checks the device ACK.
//   clk, reset                : system clock, asynchronous active-high reset
//   bus                       : command handshake and status pulses (slave side)
//   ps2_clk_in, ps2_data_in   : raw keyb_clk / keyb_data levels
//   ps2_clk_oe, ps2_data_oe   : open-drain enables, 1 pulls the line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned SETUP_CYCLES         = 50,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic            clk,
  input  logic            reset,
  ps2_host_tx_if.slave    bus,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe
);

  localparam int unsigned MaxAB = (INHIBIT_CYCLES > SETUP_CYCLES) ?
                                  INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MaxCD = (START_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                                  START_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned FrameBits = PS2_DATA_BITS + 2;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t InhibitLast = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t SetupLast   = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t StartLast   = cnt_t'(START_TIMEOUT_CYCLES - 1);
  localparam cnt_t BitLast     = cnt_t'(BIT_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] StopIdx = 4'(FrameBits - 1);

  ps2_tx_state_t          state_q, state_d;
  cnt_t                   cnt_q, cnt_d, cnt_inc;
  logic [FrameBits-1:0]   frame_q, frame_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic                   drive_q, drive_d;
  logic                   ack_err_q, ack_err_d;

  logic clk_level, clk_fall;
  logic data_level, unused_data_fall;
  logic lines_idle;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_data_in),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  assign lines_idle = clk_level & data_level;

  // Saturating so a long wait never wraps back under a timeout threshold.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      frame_q   <= '0;
      bit_idx_q <= '0;
      drive_q   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      drive_q   <= drive_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    drive_d   = drive_q;
    ack_err_d = ack_err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.tx_valid) begin
          state_d   = StInhibit;
          frame_d   = {1'b1, ps2_odd_parity(bus.tx_data), bus.tx_data};
          bit_idx_d = '0;
          drive_d   = 1'b0;
          ack_err_d = 1'b0;
        end
      end
      StInhibit: begin
        if (cnt_q >= InhibitLast) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (cnt_q >= SetupLast) begin
          state_d = StWaitFirst;
          cnt_d   = '0;
        end
      end
      StWaitFirst: begin
        if (clk_fall) begin
          drive_d   = ~frame_q[0];
          bit_idx_d = 4'd1;
          state_d   = StShift;
          cnt_d     = '0;
        end else if (cnt_q >= StartLast) begin
          state_d = StAbort;
        end
      end
      StShift: begin
        if (clk_fall) begin
          cnt_d     = '0;
          drive_d   = ~frame_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          // Stop bit (a release) is being presented: next edge carries the ACK.
          if (bit_idx_q == StopIdx) begin
            state_d = StAck;
          end
        end else if (cnt_q >= BitLast) begin
          state_d = StAbort;
        end
      end
      StAck: begin
        if (clk_fall) begin
          ack_err_d = data_level;
          state_d   = StWaitIdle;
          cnt_d     = '0;
        end else if (cnt_q >= BitLast) begin
          state_d = StAbort;
        end
      end
      StWaitIdle: begin
        if (lines_idle) begin
          state_d = StIdle;
        end else if (cnt_q >= BitLast) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decoded from registered state so an asynchronous reset releases both lines at once.
  always_comb begin
    ps2_clk_oe     = 1'b0;
    ps2_data_oe    = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.busy       = 1'b1;
    bus.tx_done    = 1'b0;
    bus.tx_ack_err = 1'b0;
    bus.tx_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.tx_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      StInhibit: begin
        ps2_clk_oe = 1'b1;
      end
      StReq: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      StWaitFirst: begin
        ps2_data_oe = 1'b1;
      end
      StShift: begin
        ps2_data_oe = drive_q;
      end
      StAck: begin
        ps2_data_oe = 1'b0;
      end
      StWaitIdle: begin
        if (lines_idle) begin
          bus.tx_done    = ~ack_err_q;
          bus.tx_ack_err = ack_err_q;
        end
      end
      StAbort: begin
        bus.tx_timeout = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the lines, a scoreboard queue
// holds the expected outcome pulse and device-observed frame per accepted byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH   = 50;
  localparam int unsigned SETUP = 10;
  localparam int unsigned START = 2000;
  localparam int unsigned BITTO = 400;
  localparam int H = 20;  // device half clock period in clk cycles

  localparam logic [2:0] KDone   = 3'b100;
  localparam logic [2:0] KAckErr = 3'b010;
  localparam logic [2:0] KTout   = 3'b001;

  typedef struct packed {
    logic [2:0] pulses;
    logic [9:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_oe, ps2_data_oe;
  logic keyb_clk, keyb_data;
  logic dev_clk_low, dev_data_low;
  logic dev_ack;
  int   dev_edges_max;
  int   dev_edges;
  logic [9:0] dev_last_frame;

  int n_tests = 0;
  int n_fail = 0;
  int n_outcomes = 0;
  int accept_outcomes = 0;
  exp_t sb_q[$];

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .SETUP_CYCLES         (SETUP),
    .START_TIMEOUT_CYCLES (START),
    .BIT_TIMEOUT_CYCLES   (BITTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ps2_clk_in  (keyb_clk),
    .ps2_data_in (keyb_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Open-drain wired-AND of host and device.
  assign keyb_clk  = !(ps2_clk_oe || dev_clk_low);
  assign keyb_data = !(ps2_data_oe || dev_data_low);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] pulses, input logic [9:0] frame);
    exp_t e;
    e.pulses = pulses;
    e.frame  = frame;
    sb_q.push_back(e);
  endtask

  // Holds tx_valid until accepted; optionally measures inhibit and setup lengths.
  task automatic send(input logic [7:0] d, input bit measure);
    int n;
    int n_inh;
    int n_req;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, bus.tx_ready}, 32'd1);
    @(posedge clk);
    accept_outcomes = n_outcomes;
    @(negedge clk);
    check("accept_latency", {29'd0, bus.busy, ps2_clk_oe, ps2_data_oe}, 32'b110);
    if (measure) begin
      n_inh = 1;
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (!(ps2_clk_oe && !ps2_data_oe) || n > 20000) break;
        n_inh++;
      end
      n_req = 0;
      n = 0;
      while (ps2_clk_oe && ps2_data_oe && n < 20000) begin
        n_req++;
        n++;
        @(negedge clk);
      end
      check("inhibit_cycles", n_inh, INH);
      check("setup_cycles", n_req, SETUP);
      check("release_state", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    end
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL outcome_wait: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Device model: answers a request-to-send with dev_edges_max clock pulses.
  initial begin
    logic [9:0] bits;
    int n_e;
    dev_clk_low    = 1'b0;
    dev_data_low   = 1'b0;
    dev_edges      = 0;
    dev_last_frame = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.busy && keyb_clk && !keyb_data) begin
        n_e = dev_edges_max;
        dev_last_frame = '0;
        bits = '0;
        repeat (H) @(posedge clk);
        for (int e = 1; e <= n_e; e++) begin
          if (e == 11) begin
            dev_data_low = dev_ack;
            repeat (H / 2) @(posedge clk);
          end
          dev_clk_low = 1'b1;
          dev_edges = e;
          repeat (H) @(posedge clk);
          dev_clk_low = 1'b0;
          if (e <= 10) bits[e-1] = keyb_data;
          if (e == 10) dev_last_frame = bits;
          repeat (H) @(posedge clk);
        end
        dev_data_low = 1'b0;
        dev_edges = 0;
        while (bus.busy) @(negedge clk);
      end
    end
  end

  // Monitor: pops the scoreboard whenever an outcome pulse appears.
  initial begin
    logic [2:0] pulses;
    exp_t e;
    bit ready_chk;
    ready_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ready_chk = 1'b0;
      end else begin
        if (ready_chk) begin
          check("ready_after_pulse", {30'd0, bus.tx_ready, bus.busy}, 32'b10);
          ready_chk = 1'b0;
        end
        pulses = {bus.tx_done, bus.tx_ack_err, bus.tx_timeout};
        if (pulses != 3'b000) begin
          n_outcomes++;
          ready_chk = 1'b1;
          check("pulse_onehot", $countones(pulses), 1);
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got %b, expected none", pulses);
          end else begin
            e = sb_q.pop_front();
            check("outcome", {29'd0, pulses}, {29'd0, e.pulses});
            check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            if (e.pulses != KTout) check("device_frame", {22'd0, dev_last_frame}, {22'd0, e.frame});
          end
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    reset         = 1'b1;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    dev_ack       = 1'b1;
    dev_edges_max = 11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_busy", {30'd0, bus.tx_ready, bus.busy}, 32'b10);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_pulses", {29'd0, bus.tx_done, bus.tx_ack_err, bus.tx_timeout}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED: 1,0,1,1,0,1,1,1 parity 1 stop 1
    push(KDone, 10'h3ED);
    send(PS2_CMD_SET_LEDS, 1'b1);
    bus.tx_valid = 1'b0;
    wait_sb();

    // Back-to-back 0xF4 (parity 0) then 0xFF (parity 1), valid held throughout.
    base = n_outcomes;
    push(KDone, 10'h2F4);
    push(KDone, 10'h3FF);
    send(PS2_CMD_ENABLE, 1'b0);
    send(PS2_CMD_RESET, 1'b0);
    check("b2b_order", accept_outcomes - base, 1);
    bus.tx_valid = 1'b0;
    wait_sb();

    // Device withholds the ACK.
    dev_ack = 1'b0;
    push(KAckErr, 10'h2F4);
    send(PS2_CMD_ENABLE, 1'b0);
    bus.tx_valid = 1'b0;
    wait_sb();
    dev_ack = 1'b1;

    // Device never clocks: timeout after START cycles in WAIT_FIRST.
    dev_edges_max = 0;
    push(KTout, 10'h000);
    send(PS2_CMD_RESET, 1'b0);
    bus.tx_valid = 1'b0;
    n = 0;
    base = 0;
    while (!bus.tx_timeout && base < 20000) begin
      if (bus.busy && !ps2_clk_oe) n++;
      @(negedge clk);
      base++;
    end
    check("start_timeout_len", n, START);
    wait_sb();

    // Device stops after bit 4.
    dev_edges_max = 5;
    push(KTout, 10'h000);
    send(PS2_CMD_SET_LEDS, 1'b0);
    bus.tx_valid = 1'b0;
    wait_sb();

    // Reset in the middle of SHIFT (after the fifth edge).
    send(8'h5A, 1'b0);
    bus.tx_valid = 1'b0;
    n = 0;
    while (dev_edges != 5 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("reached_bit5", dev_edges, 5);
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset_ready_busy", {30'd0, bus.tx_ready, bus.busy}, 32'b10);
    check("reset_pulses", {29'd0, bus.tx_done, bus.tx_ack_err, bus.tx_timeout}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);

    // 0x00 after reset: parity 1.
    dev_edges_max = 11;
    push(KDone, 10'h300);
    send(8'h00, 1'b0);
    bus.tx_valid = 1'b0;
    wait_sb();

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Drives the shared keyb_clk/keyb_data lines through open-drain enables and runs the PS/2 request-to-send sequence.
- The device generates the clock. This block shifts out start, 8 data bits, odd parity and stop, then checks the device ACK.
- It sits beside the PS/2 scan-code receiver on the same two wires. It reports busy so the receiver can ignore frames while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the keyboard clock is held low before the request (100 us at 50 MHz).
- SETUP_CYCLES, 50: clk cycles data is held low while the clock is still low, before the clock is released.
- START_TIMEOUT_CYCLES, 750000: maximum clk cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT_CYCLES, 100000: maximum clk cycles between successive device falling edges (2 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high in IDLE only; transfer accepted when tx_valid && tx_ready
- ps2_clk_in  in  1  sampled keyb_clk line
- ps2_data_in  in  1  sampled keyb_data line
- ps2_clk_oe  out  1  1 = pull keyb_clk low, 0 = release
- ps2_data_oe  out  1  1 = pull keyb_data low, 0 = release
- busy  out  1  high in any state except IDLE
- tx_done  out  1  one-cycle pulse: frame sent and ACK seen
- tx_ack_err  out  1  one-cycle pulse: no ACK (data high at ACK sample)
- tx_timeout  out  1  one-cycle pulse: device clock missing

Behaviour:
- Reset, applied asynchronously:
  - state=IDLE.
  - ps2_clk_oe=0, ps2_data_oe=0: both lines released immediately, including mid-frame.
  - busy=0, tx_ready=1 (reflects IDLE), all pulse outputs 0.
  - Counters cleared.
- Line inputs:
  - Each line passes through a 2-FF synchronizer.
  - A falling edge is the synchronized level going 1 to 0 (previous=1, current=0).
  - All protocol decisions use synchronized values only.
- Frame register:
  - On accept, latch frame = {1'b1 stop, parity, tx_data}.
  - parity = ~^tx_data (odd parity).
  - bit_idx is cleared to 0.
- States:
  - IDLE: both oe=0. On accept, go to INHIBIT and clear the counter.
  - INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_CYCLES, go to REQ.
  - REQ: clk_oe=1, data_oe=1 (this is the start bit). After SETUP_CYCLES, go to WAIT_FIRST.
  - WAIT_FIRST: clk_oe=0, data_oe=1.
    - On a falling edge: data_oe = ~frame[0], bit_idx=1, go to SHIFT.
    - If START_TIMEOUT_CYCLES elapse with no edge: go to ABORT.
  - SHIFT: on each falling edge, data_oe = ~frame[bit_idx] and bit_idx increments.
    - bit_idx 1..7 present data bits 1..7.
    - bit_idx 8 presents parity.
    - bit_idx 9 presents stop, which gives data_oe=0.
    - After the stop bit is presented, go to ACK.
    - The edge-gap counter resets on every edge. A gap of BIT_TIMEOUT_CYCLES goes to ABORT.
  - ACK: data_oe=0.
    - On the next falling edge, sample ps2_data_in. 0 means ACK OK; 1 means ACK error.
    - Go to WAIT_IDLE, recording the result.
    - A BIT_TIMEOUT_CYCLES gap goes to ABORT.
  - WAIT_IDLE: wait until synchronized clk and data are both 1.
    - Then pulse tx_done (ACK OK) or tx_ack_err (ACK error).
    - Go to IDLE on the same cycle as the pulse.
    - A BIT_TIMEOUT_CYCLES gap goes to ABORT.
  - ABORT: both oe=0, pulse tx_timeout for one cycle, go to IDLE.
- Data changes only while the device clock is low, i.e. on a falling edge, so the device samples on the rising edge.
- Latency from accept to the start of clock inhibit is 1 cycle.
- tx_valid while busy is ignored: no queueing and no corruption of the latched frame.
- Exactly one of tx_done, tx_ack_err, tx_timeout pulses per accepted byte. They never pulse together.
- Counters are sized to the largest parameter ($clog2). A counter saturates and never wraps while waiting.

Decomposition:
- Shared package ps2_pkg holds:
  - typedef ps2_tx_state_t (IDLE, INHIBIT, REQ, WAIT_FIRST, SHIFT, ACK, WAIT_IDLE, ABORT);
  - localparams PS2_DATA_BITS=8, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF;
  - function ps2_odd_parity.
- One sub-module, ps2_line_sync: 2-FF synchronizer plus falling-edge detector for one line.
  - ps2_host_tx instantiates it for each line.
  - The receiver is expected to reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - clk_oe low for 5000 cycles, then data low.
  - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; busy falls; tx_ready returns 1.
- Send 0xF4 and 0xFF back-to-back (second tx_valid asserted while busy, held):
  - 0xF4 parity 0, 0xFF parity 1.
  - The second byte is accepted only after the first tx_done.
- Device model omits the ACK (data stays high at the 11th edge) -> tx_ack_err pulses, no tx_done, both oe=0.
- Device model never clocks after release -> tx_timeout after 750000 cycles of WAIT_FIRST; lines released.
- Device model stops clocking after bit 4 -> tx_timeout after 100000 idle cycles; state IDLE; tx_ready=1.
- Assert reset during SHIFT (bit_idx=5) -> ps2_clk_oe/ps2_data_oe=0 in the same cycle; busy=0; no pulse outputs; a subsequent 0x00 send succeeds with parity 1.
